// File: rtl/shifter_operand_pipe.sv
// Pipelined ARM shifter-operand unit: forms the second ALU operand and shifter
// carry for the immediate, register and register-shifted addressing modes.
module shifter_operand_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode_in,
  input  logic [WIDTH-1:0] rm_in,
  input  logic [7:0]       rs_in,
  input  logic [11:0]      shift_in,
  input  logic             carry_in,
  input  logic             flush_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shifter_out,
  output logic             shifter_carry_out,
  output logic             illegal_mode
);

  localparam int SHAMT_W = $clog2(WIDTH);
  // Wide enough for an 8-bit Rs amount and for the value WIDTH itself.
  localparam int AMT_W   = (SHAMT_W + 1 > 8) ? SHAMT_W + 1 : 8;

  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR, SH_ASR, SH_ROR} sh_type_e;
  typedef enum logic [1:0] {K_SHIFT, K_RRX, K_ILLEGAL} kind_e;

  typedef struct packed {
    kind_e            kind;
    sh_type_e         sh_type;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] opnd;
    logic             carry;
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             carry;
    logic             illegal;
  } res_t;

  // Every mode is folded onto one register-shift style operation: immediates
  // become the operand, and the imm-shift #0 encodings become amount WIDTH or RRX.
  function automatic op_t decode(input logic [2:0]       mode,
                                 input logic [WIDTH-1:0] rm,
                                 input logic [7:0]       rs,
                                 input logic [11:0]      sh,
                                 input logic             c);
    op_t d;
    d.kind    = K_SHIFT;
    d.sh_type = sh_type_e'(sh[6:5]);
    d.amount  = '0;
    d.opnd    = rm;
    d.carry   = c;
    case (mode)
      3'b000: begin
        if (sh[11:7] != 5'd0)        d.amount = AMT_W'(sh[11:7]);
        else if (d.sh_type == SH_ROR) d.kind   = K_RRX;
        else if (d.sh_type != SH_LSL) d.amount = AMT_W'(WIDTH);
      end
      3'b001: begin
        d.sh_type = SH_ROR;
        d.amount  = AMT_W'({sh[11:8], 1'b0});
        d.opnd    = WIDTH'(sh[7:0]);
      end
      3'b010:  d.opnd   = WIDTH'(sh);
      3'b011:  d.amount = '0;
      3'b100:  d.amount = AMT_W'(rs);
      default: begin
        d.kind = K_ILLEGAL;
        d.opnd = '0;
      end
    endcase
    return d;
  endfunction

  function automatic res_t compute(input op_t d);
    res_t             r;
    logic [SHAMT_W-1:0] s, s_neg, s_m1;
    logic             in_range;
    r.value  = d.opnd;
    r.carry  = d.carry;
    r.illegal = 1'b0;
    s        = d.amount[SHAMT_W-1:0];
    s_neg    = -s;
    s_m1     = s - SHAMT_W'(1);
    in_range = d.amount < AMT_W'(WIDTH);
    case (d.kind)
      K_ILLEGAL: begin
        r.value   = '0;
        r.illegal = 1'b1;
      end
      K_RRX: begin
        r.value = {d.carry, d.opnd[WIDTH-1:1]};
        r.carry = d.opnd[0];
      end
      default: begin
        if (d.amount != '0) begin
          case (d.sh_type)
            SH_LSL: begin
              if (in_range) begin
                r.value = d.opnd << s;
                r.carry = d.opnd[s_neg];
              end else begin
                r.value = '0;
                r.carry = (d.amount == AMT_W'(WIDTH)) ? d.opnd[0] : 1'b0;
              end
            end
            SH_LSR: begin
              if (in_range) begin
                r.value = d.opnd >> s;
                r.carry = d.opnd[s_m1];
              end else begin
                r.value = '0;
                r.carry = (d.amount == AMT_W'(WIDTH)) ? d.opnd[WIDTH-1] : 1'b0;
              end
            end
            SH_ASR: begin
              if (in_range) begin
                r.value = $unsigned($signed(d.opnd) >>> s);
                r.carry = d.opnd[s_m1];
              end else begin
                r.value = {WIDTH{d.opnd[WIDTH-1]}};
                r.carry = d.opnd[WIDTH-1];
              end
            end
            default: begin
              // Rotation is modulo WIDTH; a whole-turn rotate still reports bit MSB.
              if (s == '0) begin
                r.carry = d.opnd[WIDTH-1];
              end else begin
                r.value = (d.opnd >> s) | (d.opnd << s_neg);
                r.carry = d.opnd[s_m1];
              end
            end
          endcase
        end
      end
    endcase
    return r;
  endfunction

  logic out_adv;
  logic fin_valid;
  op_t  fin_op;
  res_t fin_res;

  assign out_adv = !out_valid || out_ready;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic s1_valid;
      logic s1_adv;
      op_t  s1_op;

      assign s1_adv   = !s1_valid || out_adv;
      assign in_ready = s1_adv;

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and stage order inside the block does not matter.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_op    <= '0;
        end else begin
          if (flush_in)    s1_valid <= 1'b0;
          else if (s1_adv) s1_valid <= in_valid;
          if (s1_adv && in_valid) s1_op <= decode(mode_in, rm_in, rs_in, shift_in, carry_in);
        end
      end

      assign fin_valid = s1_valid;
      assign fin_op    = s1_op;
    end else begin : g_one
      assign in_ready  = out_adv;
      assign fin_valid = in_valid;
      assign fin_op    = decode(mode_in, rm_in, rs_in, shift_in, carry_in);
    end
  endgenerate

  assign fin_res = compute(fin_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      shifter_out       <= '0;
      shifter_carry_out <= 1'b0;
      illegal_mode      <= 1'b0;
    end else begin
      if (flush_in)     out_valid <= 1'b0;
      else if (out_adv) out_valid <= fin_valid;
      // Payload only moves with a real transfer, so it stays put under a stall.
      if (!flush_in && out_adv && fin_valid) begin
        shifter_out       <= fin_res.value;
        shifter_carry_out <= fin_res.carry;
        illegal_mode      <= fin_res.illegal;
      end
    end
  end

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Directed bench for shifter_operand_pipe (WIDTH=32, PIPE_STAGES=2) with
// hand-computed operands, carries, handshake, flush and reset behaviour.
module tb_shifter_operand_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   mode_in = '0;
  logic [W-1:0] rm_in = '0;
  logic [7:0]   rs_in = '0;
  logic [11:0]  shift_in = '0;
  logic         carry_in = 1'b0;
  logic         flush_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] shifter_out;
  logic         shifter_carry_out;
  logic         illegal_mode;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] got[$];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  shifter_operand_pipe #(.WIDTH(W), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode_in(mode_in), .rm_in(rm_in), .rs_in(rs_in), .shift_in(shift_in),
    .carry_in(carry_in), .flush_in(flush_in), .out_valid(out_valid),
    .out_ready(out_ready), .shifter_out(shifter_out),
    .shifter_carry_out(shifter_carry_out), .illegal_mode(illegal_mode)
  );

  // Records each completed output transfer, for the in-order/no-duplicate check.
  always @(negedge clk) if (mon_en && out_valid && out_ready) got.push_back(shifter_out);

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] m, input logic [W-1:0] rm, input logic [7:0] rs,
                        input logic [11:0] sh, input logic c);
    mode_in  = m;
    rm_in    = rm;
    rs_in    = rs;
    shift_in = sh;
    carry_in = c;
  endtask

  // One isolated op: accepted on the next edge, visible one edge later.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [W-1:0] rm,
                        input logic [7:0] rs, input logic [11:0] sh, input logic c,
                        input logic [W-1:0] exp_v, input logic exp_c, input logic exp_ill);
    set_op(m, rm, rs, sh, c);
    in_valid = 1'b1;
    #1;
    check({tag, "/in_ready"}, 64'(in_ready), 64'(1'b1));
    tick();
    in_valid = 1'b0;
    check({tag, "/latency"}, 64'(out_valid), 64'(1'b0));
    tick();
    check({tag, "/valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "/out"}, 64'(shifter_out), 64'(exp_v));
    check({tag, "/carry"}, 64'(shifter_carry_out), 64'(exp_c));
    check({tag, "/illegal"}, 64'(illegal_mode), 64'(exp_ill));
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst/out_valid", 64'(out_valid), 64'(1'b0));
    check("rst/out", 64'(shifter_out), 64'h0);
    check("rst/carry", 64'(shifter_carry_out), 64'(1'b0));
    check("rst/illegal", 64'(illegal_mode), 64'(1'b0));
    rst_n = 1'b1;
    #1;
    check("rst/in_ready", 64'(in_ready), 64'(1'b1));
    tick();

    // Immediate shifts, rm = 0x80000001
    run_op("lsl0", 3'b000, 32'h8000_0001, 8'd0, 12'h000, 1'b0, 32'h8000_0001, 1'b0, 1'b0);
    run_op("lsr0", 3'b000, 32'h8000_0001, 8'd0, 12'h020, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("asr0", 3'b000, 32'h8000_0001, 8'd0, 12'h040, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("rrx",  3'b000, 32'h8000_0001, 8'd0, 12'h060, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    run_op("lsl4", 3'b000, 32'h8000_0001, 8'd0, 12'h200, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
    run_op("lsr1", 3'b000, 32'h8000_0001, 8'd0, 12'h0A0, 1'b0, 32'h4000_0000, 1'b1, 1'b0);
    run_op("asr4", 3'b000, 32'h8000_0001, 8'd0, 12'h240, 1'b1, 32'hF800_0000, 1'b0, 1'b0);
    run_op("ror4", 3'b000, 32'h8000_0001, 8'd0, 12'h260, 1'b1, 32'h1800_0000, 1'b0, 1'b0);

    // Rotated immediate, load/store immediate, register pass
    run_op("rot4",  3'b001, 32'h0, 8'd0, 12'h4FF, 1'b0, 32'hFF00_0000, 1'b1, 1'b0);
    run_op("rot0",  3'b001, 32'h0, 8'd0, 12'h0FF, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
    run_op("rot1",  3'b001, 32'h0, 8'd0, 12'h1FF, 1'b0, 32'hC000_003F, 1'b1, 1'b0);
    run_op("ldst",  3'b010, 32'hFFFF_FFFF, 8'd0, 12'hABC, 1'b0, 32'h0000_0ABC, 1'b0, 1'b0);
    run_op("rpass", 3'b011, 32'h1234_5678, 8'd0, 12'h000, 1'b1, 32'h1234_5678, 1'b1, 1'b0);

    // Register-specified shifts
    run_op("rs_lsl32",  3'b100, 32'h3, 8'd32,  12'h000, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op("rs_lsl33",  3'b100, 32'h3, 8'd33,  12'h000, 1'b1, 32'h0, 1'b0, 1'b0);
    run_op("rs_lsl255", 3'b100, 32'h3, 8'd255, 12'h000, 1'b1, 32'h0, 1'b0, 1'b0);
    run_op("rs_ror32",  3'b100, 32'h3, 8'd32,  12'h060, 1'b1, 32'h3, 1'b0, 1'b0);
    run_op("rs_ror1",   3'b100, 32'h3, 8'd1,   12'h060, 1'b0, 32'h8000_0001, 1'b1, 1'b0);
    run_op("rs_ror36",  3'b100, 32'h3, 8'd36,  12'h060, 1'b1, 32'h3000_0000, 1'b0, 1'b0);
    run_op("rs_zero",   3'b100, 32'h3, 8'd0,   12'h040, 1'b1, 32'h3, 1'b1, 1'b0);
    run_op("rs_lsr32",  3'b100, 32'h8000_0000, 8'd32, 12'h020, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op("rs_lsr31",  3'b100, 32'h8000_0000, 8'd31, 12'h020, 1'b1, 32'h1, 1'b0, 1'b0);
    run_op("rs_asr40",  3'b100, 32'h8000_0000, 8'd40, 12'h040, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Reserved modes
    run_op("rsvd101", 3'b101, 32'hFFFF, 8'd0, 12'hFFF, 1'b1, 32'h0, 1'b1, 1'b1);
    run_op("rsvd111", 3'b111, 32'hFFFF, 8'd0, 12'h000, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Backpressure: four back-to-back ops, consumer stalls three cycles
    got.delete();
    mon_en = 1'b1;
    set_op(3'b011, 32'h11, 8'd0, 12'h000, 1'b0);
    in_valid = 1'b1;
    tick();
    check("bp/first_latency", 64'(out_valid), 64'(1'b0));
    rm_in = 32'h22;
    tick();
    check("bp/a_valid", 64'(out_valid), 64'(1'b1));
    check("bp/a_out", 64'(shifter_out), 64'h11);
    out_ready = 1'b0;
    rm_in = 32'h33;
    #1;
    check("bp/in_ready_drop", 64'(in_ready), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp/hold_valid", 64'(out_valid), 64'(1'b1));
      check("bp/hold_out", 64'(shifter_out), 64'h11);
      check("bp/hold_ready", 64'(in_ready), 64'(1'b0));
    end
    out_ready = 1'b1;
    #1;
    check("bp/in_ready_back", 64'(in_ready), 64'(1'b1));
    tick();
    check("bp/b_out", 64'(shifter_out), 64'h22);
    rm_in = 32'h44;
    tick();
    check("bp/c_out", 64'(shifter_out), 64'h33);
    in_valid = 1'b0;
    tick();
    check("bp/d_out", 64'(shifter_out), 64'h44);
    tick();
    check("bp/drained", 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("bp/count", 64'(got.size()), 64'd4);
    if (got.size() == 4) begin
      check("bp/order0", 64'(got[0]), 64'h11);
      check("bp/order1", 64'(got[1]), 64'h22);
      check("bp/order2", 64'(got[2]), 64'h33);
      check("bp/order3", 64'(got[3]), 64'h44);
    end
    tick();

    // Flush with two ops in flight plus one presented
    out_ready = 1'b0;
    set_op(3'b011, 32'hA1, 8'd0, 12'h000, 1'b0);
    in_valid = 1'b1;
    tick();
    rm_in = 32'hA2;
    tick();
    check("fl/in_flight", 64'(out_valid), 64'(1'b1));
    rm_in = 32'hA3;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    in_valid = 1'b0;
    check("fl/cleared", 64'(out_valid), 64'(1'b0));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl/stays_empty", 64'(out_valid), 64'(1'b0));
    end

    // Flush wins over an accept into an empty pipe
    set_op(3'b011, 32'hB1, 8'd0, 12'h000, 1'b0);
    in_valid = 1'b1;
    flush_in = 1'b1;
    #1;
    check("fl2/in_ready", 64'(in_ready), 64'(1'b1));
    tick();
    flush_in = 1'b0;
    in_valid = 1'b0;
    tick();
    check("fl2/dropped_a", 64'(out_valid), 64'(1'b0));
    tick();
    check("fl2/dropped_b", 64'(out_valid), 64'(1'b0));
    run_op("post_flush", 3'b011, 32'h55, 8'd0, 12'h000, 1'b0, 32'h55, 1'b0, 1'b0);
    tick();

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    set_op(3'b011, 32'hC1, 8'd0, 12'h000, 1'b1);
    in_valid = 1'b1;
    tick();
    rm_in = 32'hC2;
    tick();
    in_valid = 1'b0;
    check("mr/in_flight", 64'(out_valid), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mr/out_valid", 64'(out_valid), 64'(1'b0));
    check("mr/out", 64'(shifter_out), 64'h0);
    check("mr/carry", 64'(shifter_carry_out), 64'(1'b0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_op("after_reset", 3'b011, 32'hD1, 8'd0, 12'h000, 1'b0, 32'hD1, 1'b0, 1'b0);
    tick();
    check("after_reset/drained", 64'(out_valid), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shifter_operand_pipe.md
Name: shifter_operand_pipe

Overview:
- Pipelined, parametrised successor to the combinational shifter-operand unit in the ARM datapath; sits between register-file read and the ALU in the EX stage.
- Produces the second ALU operand and the shifter carry-out for five addressing modes, including register-specified shifts.
- Carry-out follows full ARM shifter-operand semantics.
- Uses a valid/ready handshake with stall and flush so the hazard unit can hold or squash operations in flight.

Parameters:
- WIDTH, 32, operand width; power of two, ≥16. SHAMT_W = log2(WIDTH).
- PIPE_STAGES, 2, latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an input this cycle.
- mode_in  in  3  000 imm-shift, 001 rotated-imm, 010 ldst-imm, 011 reg-pass, 100 reg-shift; 101–111 reserved.
- rm_in  in  WIDTH  Rm value.
- rs_in  in  8  Rs[7:0], the shift amount for reg-shift.
- shift_in  in  12  instruction bits [11:0].
- carry_in  in  1  current CPSR C flag.
- flush_in  in  1  synchronous squash of all in-flight operations.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- shifter_out  out  WIDTH  operand result.
- shifter_carry_out  out  1  shifter carry.
- illegal_mode  out  1  result came from a reserved mode; valid with out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valids 0; out_valid=0.
  - shifter_out=0, shifter_carry_out=0, illegal_mode=0.
  - in_ready=1 once rst_n deasserts.
- Pipeline: PIPE_STAGES registered stages.
  - Stage 1 decodes: latches mode, type=shift_in[6:5], amount, rm, carry_in.
  - Final stage computes the result, which is registered on the outputs.
  - With PIPE_STAGES=1, decode and compute share one register.
  - Latency is PIPE_STAGES cycles from the accepting edge to out_valid.
- Handshake:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - A stage advances when it is empty or the next stage or consumer accepts.
  - in_ready = !stage1_valid | stage1_advances. It is combinational from out_ready and carries no path from in_valid.
  - Throughput is 1 per cycle with out_ready held high.
  - Output and data are held stable while out_valid=1 and out_ready=0.
- flush_in=1:
  - All stage valids clear on that edge; out_valid is 0 the next cycle.
  - An input presented in the same cycle is dropped.
  - Flush has priority over accept.
- imm-shift, n = shift_in[11:7]:
  - LSL n=0: out=rm, C=carry_in.
  - LSL n>0: out=rm<<n, C=rm[WIDTH-n].
  - LSR n=0 means LSR #32: out=0, C=rm[31].
  - LSR n>0: out=rm>>n, C=rm[n-1].
  - ASR n=0 means ASR #32: out = all bits rm[31], C=rm[31].
  - ASR n>0: arithmetic shift, C=rm[n-1].
  - ROR n=0 means RRX: out={carry_in, rm[WIDTH-1:1]}, C=rm[0].
  - ROR n>0: rotate right, C=rm[n-1].
- rotated-imm: out = zero-extended shift_in[7:0] rotated right by 2*shift_in[11:8].
  - Rotation 0: C=carry_in.
  - Otherwise: C=out[WIDTH-1].
- ldst-imm: out = zero-extended shift_in[11:0]; C=carry_in.
- reg-pass: out=rm; C=carry_in.
- reg-shift, a = rs_in[7:0]:
  - a=0, any type: out=rm, C=carry_in.
  - LSL: a<WIDTH as imm LSL; a=WIDTH gives out=0, C=rm[0]; a>WIDTH gives out=0, C=0.
  - LSR: a<WIDTH as imm LSR; a=WIDTH gives out=0, C=rm[WIDTH-1]; a>WIDTH gives out=0, C=0.
  - ASR: a≥WIDTH gives out = all sign bits, C=rm[WIDTH-1].
  - ROR: r = a[SHAMT_W-1:0]. r=0 gives out=rm, C=rm[WIDTH-1]. Otherwise rotate by r, C=rm[r-1].
- Reserved modes: out=0, C=carry_in, illegal_mode=1.
- Implementation: single-cycle barrel shifter per stage. No loops or iteration counters; all shifts are constant-time.

Test Plan:
- Reset mid-stream: 2 ops in flight, rst_n low → next cycle out_valid=0, shifter_out=0. After release, first new op appears after PIPE_STAGES cycles.
- Imm-shift edges, rm=0x80000001, carry_in=0:
  - LSL#0 → 0x80000001, C=0.
  - LSR#0 → 0, C=1.
  - ASR#0 → 0xFFFFFFFF, C=1.
  - RRX with carry_in=1 → 0xC0000000, C=1.
- Rotated-imm: imm8=0xFF, rot=4 → 0xFF000000, C=1. Rot=0, carry_in=1 → 0x000000FF, C=1.
- Reg-shift, rm=0x00000003: LSL 32 → 0, C=1; LSL 33 → 0, C=0; ROR 32 → 0x00000003, C=0; ROR 1 → 0x80000001, C=1.
- Backpressure: 4 back-to-back ops, out_ready low for 3 cycles mid-stream → in_ready drops, outputs held stable, all 4 results delivered in order, none duplicated.
- Flush with in_valid=1 and 2 ops in flight → no out_valid for those 3 ops. Reserved mode 101 → illegal_mode=1, out=0.
